// File: rtl/register_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Package     : register_scoreboard_pkg
// Description : Shared widths, latency constants and types for the register
//               hazard scoreboard of the multicycle MIPS pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package register_scoreboard_pkg;

    localparam int NUM_REGS     = 32;
    localparam int REG_W        = 5;
    localparam int LAT_W        = 3;
    localparam int TAG_W        = 3;
    // One tag value is kept in reserve so a live tag is never reused while
    // an older write carrying it is still in flight.
    localparam int MAX_INFLIGHT = (1 << TAG_W) - 1;

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [LAT_W-1:0] lat_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Cycles until a result can be forwarded, by producer class.
    localparam lat_t LAT_ALU  = 3'd1;
    localparam lat_t LAT_LOAD = 3'd2;

endpackage : register_scoreboard_pkg
`default_nettype wire

// File: rtl/register_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Interface   : register_scoreboard_if
// Description : Issue (ID), retire (WB) and status signals of the register
//               scoreboard.
//               master : pipeline side - drives issue/retire/control,
//                        receives stall, issue_tag, busy_vec
//               slave  : scoreboard side
// Revision    : 1.0 - initial release
// ============================================================================
interface register_scoreboard_if;
    import register_scoreboard_pkg::*;

    logic                flush;
    logic                forwarding_enable;
    logic                issue_valid;
    logic                issue_wb_en;
    reg_idx_t            issue_dest;
    lat_t                issue_lat;
    reg_idx_t            src1;
    reg_idx_t            src2;
    reg_idx_t            src3;
    logic [2:0]          src_en;
    logic                stall;
    tag_t                issue_tag;
    logic                wb_valid;
    reg_idx_t            wb_dest;
    tag_t                wb_tag;
    logic [NUM_REGS-1:0] busy_vec;

    modport master (
        output flush, forwarding_enable, issue_valid, issue_wb_en, issue_dest,
               issue_lat, src1, src2, src3, src_en, wb_valid, wb_dest, wb_tag,
        input  stall, issue_tag, busy_vec
    );

    modport slave (
        input  flush, forwarding_enable, issue_valid, issue_wb_en, issue_dest,
               issue_lat, src1, src2, src3, src_en, wb_valid, wb_dest, wb_tag,
        output stall, issue_tag, busy_vec
    );

endinterface : register_scoreboard_if
`default_nettype wire

// File: rtl/register_scoreboard_entry.sv
`default_nettype none
// ============================================================================
// Module      : register_scoreboard_entry
// Description : Tracking state for one architectural register: busy flag,
//               forwardability countdown and the tag of the newest write.
//   clk, rst   clock, asynchronous active-high reset
//   i_flush    clear busy and countdown (tag kept)
//   i_set      newest write to this register accepted; load lat and tag
//   i_set_lat  countdown start value
//   i_set_tag  tag of the accepted write
//   i_clr      a write to this register retires
//   i_clr_tag  tag of the retiring write
//   o_busy     register has an outstanding write
//   o_cnt      cycles left until the result is forwardable
// Revision    : 1.0 - initial release
// ============================================================================
module register_scoreboard_entry
    import register_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_set,
    input  lat_t i_set_lat,
    input  tag_t i_set_tag,
    input  logic i_clr,
    input  tag_t i_clr_tag,
    output logic o_busy,
    output lat_t o_cnt
);

    logic r_busy;
    lat_t r_cnt;
    tag_t r_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_tag  <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_set) begin
            // A new write overrides any same-cycle retire of the older one.
            r_busy <= 1'b1;
            r_cnt  <= i_set_lat;
            r_tag  <= i_set_tag;
        end else begin
            // Only the write that owns the current tag may release the
            // register; a stale retire of an overwritten value is ignored.
            if (i_clr && (r_tag == i_clr_tag)) begin
                r_busy <= 1'b0;
            end
            if (r_busy && (r_cnt != '0)) begin
                r_cnt <= r_cnt - lat_t'(1);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_cnt  = r_cnt;

endmodule : register_scoreboard_entry
`default_nettype wire

// File: rtl/register_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : register_scoreboard
// Description : Producer-side hazard tracker. Records each in-flight register
//               write from issue to write-back, counts down until the value is
//               forwardable, and stalls ID when a source cannot be covered.
//   clk, rst   clock, asynchronous active-high reset
//   sb         register_scoreboard_if.slave (issue, retire, stall, tags,
//              busy_vec debug view)
// Revision    : 1.0 - initial release
// ============================================================================
module register_scoreboard
    import register_scoreboard_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    register_scoreboard_if.slave sb
);

    logic [NUM_REGS-1:0] w_busy;
    lat_t                w_cnt [NUM_REGS];
    reg_idx_t            w_src [3];
    logic [2:0]          w_hazard;
    logic                w_full;
    logic                w_stall;
    logic                w_track;
    logic                w_retire;
    tag_t                r_next_tag;
    tag_t                r_inflight;

    assign w_src[0] = sb.src1;
    assign w_src[1] = sb.src2;
    assign w_src[2] = sb.src3;

    // r0 is hard-wired and never has an outstanding write.
    assign w_busy[0] = 1'b0;
    assign w_cnt[0]  = '0;

    // Hazards depend on registered state only: a same-cycle write-back does
    // not release a stalled consumer.
    always_comb begin
        w_hazard = '0;
        for (int s = 0; s < 3; s++) begin
            w_hazard[s] = sb.src_en[s] && (w_src[s] != '0) && w_busy[w_src[s]] &&
                          (!sb.forwarding_enable || (w_cnt[w_src[s]] != '0));
        end
    end

    assign w_full  = (r_inflight == tag_t'(MAX_INFLIGHT));
    assign w_stall = sb.issue_valid && ((|w_hazard) || (sb.issue_wb_en && w_full));

    // Flush overrides any issue or retire in the same cycle.
    assign w_track  = sb.issue_valid && !w_stall && sb.issue_wb_en &&
                      (sb.issue_dest != '0) && !sb.flush;
    // A retire with nothing in flight is dropped so the count cannot wrap.
    assign w_retire = sb.wb_valid && (r_inflight != '0) && !sb.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_next_tag <= '0;
            r_inflight <= '0;
        end else if (sb.flush) begin
            r_inflight <= '0;
        end else begin
            if (w_track) begin
                r_next_tag <= r_next_tag + tag_t'(1);
            end
            case ({w_track, w_retire})
                2'b10:   r_inflight <= r_inflight + tag_t'(1);
                2'b01:   r_inflight <= r_inflight - tag_t'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
        register_scoreboard_entry u_entry (
            .clk       (clk),
            .rst       (rst),
            .i_flush   (sb.flush),
            .i_set     (w_track && (sb.issue_dest == reg_idx_t'(i))),
            .i_set_lat (sb.issue_lat),
            .i_set_tag (r_next_tag),
            .i_clr     (w_retire && (sb.wb_dest == reg_idx_t'(i))),
            .i_clr_tag (sb.wb_tag),
            .o_busy    (w_busy[i]),
            .o_cnt     (w_cnt[i])
        );
    end

    assign sb.stall     = w_stall;
    assign sb.issue_tag = r_next_tag;
    assign sb.busy_vec  = w_busy;

endmodule : register_scoreboard
`default_nettype wire

// File: tb/tb_register_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_scoreboard
// Description : Directed self-checking bench for register_scoreboard.
//               Inputs change 1 time unit after the rising edge; outputs are
//               sampled 1 time unit later, well before the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_scoreboard;
    import register_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    register_scoreboard_if sb_if ();

    register_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        sb_if.flush       = 1'b0;
        sb_if.issue_valid = 1'b0;
        sb_if.issue_wb_en = 1'b0;
        sb_if.issue_dest  = '0;
        sb_if.issue_lat   = '0;
        sb_if.src1        = '0;
        sb_if.src2        = '0;
        sb_if.src3        = '0;
        sb_if.src_en      = '0;
        sb_if.wb_valid    = 1'b0;
        sb_if.wb_dest     = '0;
        sb_if.wb_tag      = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_issue(input logic wb_en, input reg_idx_t dest, input lat_t lat,
                               input logic [2:0] en, input reg_idx_t s1,
                               input reg_idx_t s2, input reg_idx_t s3);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_wb_en = wb_en;
        sb_if.issue_dest  = dest;
        sb_if.issue_lat   = lat;
        sb_if.src_en      = en;
        sb_if.src1        = s1;
        sb_if.src2        = s2;
        sb_if.src3        = s3;
    endtask

    task automatic drive_retire(input reg_idx_t dest, input tag_t tag);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_dest  = dest;
        sb_if.wb_tag   = tag;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        sb_if.forwarding_enable = 1'b1;
        drive_issue(1'b1, 5'd1, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.busy_vec !== 32'h0) $display("FAIL reset_busy_init: got %h want %h", sb_if.busy_vec, 32'h0);
        else n_pass++;
        n_checks++;
        if (sb_if.issue_tag !== 3'd0) $display("FAIL reset_tag_init: got %0d want 0", sb_if.issue_tag);
        else n_pass++;
        n_checks++;
        if (sb_if.stall !== 1'b0) $display("FAIL reset_first_issue_stall: got %b want 0", sb_if.stall);
        else n_pass++;
        next_cycle();
        drive_issue(1'b1, 5'd2, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive_issue(1'b1, 5'd3, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        next_cycle();
        n_checks++;
        if (sb_if.busy_vec !== 32'h0000_000E) $display("FAIL reset_three_busy: got %h want %h", sb_if.busy_vec, 32'h0000_000E);
        else n_pass++;
        n_checks++;
        if (sb_if.issue_tag !== 3'd3) $display("FAIL reset_tag_after3: got %0d want 3", sb_if.issue_tag);
        else n_pass++;
        // Asynchronous: must take effect between clock edges.
        rst = 1'b1;
        #1;
        n_checks++;
        if (sb_if.busy_vec !== 32'h0) $display("FAIL reset_async_busy: got %h want %h", sb_if.busy_vec, 32'h0);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (sb_if.issue_tag !== 3'd0) $display("FAIL reset_tag_cleared: got %0d want 0", sb_if.issue_tag);
        else n_pass++;
        sb_if.forwarding_enable = 1'b0;
        drive_issue(1'b0, 5'd0, 3'd0, 3'b111, 5'd1, 5'd2, 5'd3);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0) $display("FAIL reset_no_stale_hazard: got %b want 0", sb_if.stall);
        else n_pass++;
        sb_if.forwarding_enable = 1'b1;
        next_cycle();
    endtask

    // ------------------------------------------------------------------
    // LW r5 (lat 2), one unrelated instruction, then a user of r5: the
    // countdown reads 1 for that user, so it stalls exactly one cycle.
    task automatic test_load_use();
        do_reset();
        sb_if.forwarding_enable = 1'b1;
        drive_issue(1'b1, 5'd5, LAT_LOAD, 3'b000, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive_issue(1'b0, 5'd0, 3'd0, 3'b001, 5'd4, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0) $display("FAIL load_use_indep: got %b want 0", sb_if.stall);
        else n_pass++;
        n_checks++;
        if (sb_if.busy_vec !== 32'h0000_0020) $display("FAIL load_use_busy: got %h want %h", sb_if.busy_vec, 32'h0000_0020);
        else n_pass++;
        next_cycle();
        drive_issue(1'b0, 5'd0, 3'd0, 3'b001, 5'd5, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1) $display("FAIL load_use_stall: got %b want 1", sb_if.stall);
        else n_pass++;
        next_cycle();
        drive_issue(1'b0, 5'd0, 3'd0, 3'b001, 5'd5, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0) $display("FAIL load_use_release: got %b want 0", sb_if.stall);
        else n_pass++;
        next_cycle();
        drive_retire(5'd5, 3'd0);
        next_cycle();
        n_checks++;
        if (sb_if.busy_vec !== 32'h0) $display("FAIL load_use_retired: got %h want %h", sb_if.busy_vec, 32'h0);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_no_forwarding();
        do_reset();
        sb_if.forwarding_enable = 1'b0;
        drive_issue(1'b1, 5'd3, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive_issue(1'b0, 5'd0, 3'd0, 3'b010, 5'd0, 5'd3, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1) $display("FAIL nofwd_busy_stall: got %b want 1", sb_if.stall);
        else n_pass++;
        next_cycle();
        // Countdown is now 0: forwarding would cover it, no forwarding cannot.
        drive_issue(1'b0, 5'd0, 3'd0, 3'b010, 5'd0, 5'd3, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1) $display("FAIL nofwd_cnt0_stall: got %b want 1", sb_if.stall);
        else n_pass++;
        sb_if.forwarding_enable = 1'b1;
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0) $display("FAIL fwd_cnt0_no_stall: got %b want 0", sb_if.stall);
        else n_pass++;
        sb_if.forwarding_enable = 1'b0;
        next_cycle();
        drive_issue(1'b0, 5'd0, 3'd0, 3'b010, 5'd0, 5'd3, 5'd0);
        drive_retire(5'd3, 3'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1) $display("FAIL nofwd_no_wb_bypass: got %b want 1", sb_if.stall);
        else n_pass++;
        next_cycle();
        drive_issue(1'b0, 5'd0, 3'd0, 3'b110, 5'd0, 5'd3, 5'd3);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0) $display("FAIL nofwd_after_wb: got %b want 0", sb_if.stall);
        else n_pass++;
        next_cycle();
        sb_if.forwarding_enable = 1'b1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reissue();
        do_reset();
        sb_if.forwarding_enable = 1'b1;
        drive_issue(1'b1, 5'd7, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive_issue(1'b1, 5'd7, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.issue_tag !== 3'd1) $display("FAIL reissue_tag1: got %0d want 1", sb_if.issue_tag);
        else n_pass++;
        next_cycle();
        drive_retire(5'd7, 3'd0);
        next_cycle();
        n_checks++;
        if (sb_if.busy_vec !== 32'h0000_0080) $display("FAIL reissue_stale_retire: got %h want %h", sb_if.busy_vec, 32'h0000_0080);
        else n_pass++;
        drive_retire(5'd7, 3'd1);
        next_cycle();
        n_checks++;
        if (sb_if.busy_vec !== 32'h0) $display("FAIL reissue_owner_retire: got %h want %h", sb_if.busy_vec, 32'h0);
        else n_pass++;
        // r8 gets tag 2, then tag 3 issued in the same cycle tag 2 retires.
        drive_issue(1'b1, 5'd8, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        next_cycle();
        drive_issue(1'b1, 5'd8, 3'd3, 3'b000, 5'd0, 5'd0, 5'd0);
        drive_retire(5'd8, 3'd2);
        next_cycle();
        n_checks++;
        if (sb_if.busy_vec !== 32'h0000_0100) $display("FAIL same_cycle_issue_wins: got %h want %h", sb_if.busy_vec, 32'h0000_0100);
        else n_pass++;
        drive_issue(1'b0, 5'd0, 3'd0, 3'b100, 5'd0, 5'd0, 5'd8);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1) $display("FAIL same_cycle_new_cnt: got %b want 1", sb_if.stall);
        else n_pass++;
        next_cycle();
        drive_retire(5'd8, 3'd3);
        next_cycle();
        n_checks++;
        if (sb_if.busy_vec !== 32'h0) $display("FAIL same_cycle_final_retire: got %h want %h", sb_if.busy_vec, 32'h0);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        int n_stalls;
        do_reset();
        sb_if.forwarding_enable = 1'b1;
        // Retire with nothing in flight must be dropped.
        drive_retire(5'd5, 3'd0);
        next_cycle();
        n_stalls = 0;
        for (int i = 1; i <= 7; i++) begin
            drive_issue(1'b1, reg_idx_t'(i), 3'd0, 3'b000, 5'd0, 5'd0, 5'd0);
            #1;
            if (sb_if.stall !== 1'b0) n_stalls++;
            next_cycle();
        end
        n_checks++;
        if (n_stalls !== 0) $display("FAIL full_seven_accepted: got %0d stalls want 0", n_stalls);
        else n_pass++;
        drive_issue(1'b1, 5'd8, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1) $display("FAIL full_eighth_stall: got %b want 1", sb_if.stall);
        else n_pass++;
        n_checks++;
        if (sb_if.issue_tag !== 3'd7) $display("FAIL full_tag7: got %0d want 7", sb_if.issue_tag);
        else n_pass++;
        drive_retire(5'd1, 3'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1) $display("FAIL full_same_cycle_wb: got %b want 1", sb_if.stall);
        else n_pass++;
        next_cycle();
        drive_issue(1'b1, 5'd8, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0) $display("FAIL full_after_wb: got %b want 0", sb_if.stall);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (sb_if.issue_tag !== 3'd0) $display("FAIL full_tag_wrap: got %0d want 0", sb_if.issue_tag);
        else n_pass++;
        drive_issue(1'b0, 5'd0, 3'd0, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b0) $display("FAIL full_nowrite_ok: got %b want 0", sb_if.stall);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (sb_if.busy_vec !== 32'h0000_01FC) $display("FAIL full_busy_vec: got %h want %h", sb_if.busy_vec, 32'h0000_01FC);
        else n_pass++;
    endtask

    // ------------------------------------------------------------------
    task automatic test_flush();
        int n_stalls;
        do_reset();
        sb_if.forwarding_enable = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_issue(1'b1, reg_idx_t'(i), LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
            next_cycle();
        end
        drive_issue(1'b1, 5'd9, LAT_ALU, 3'b000, 5'd0, 5'd0, 5'd0);
        drive_retire(5'd1, 3'd0);
        sb_if.flush = 1'b1;
        #1;
        n_checks++;
        if (sb_if.issue_tag !== 3'd3) $display("FAIL flush_tag_before: got %0d want 3", sb_if.issue_tag);
        else n_pass++;
        next_cycle();
        n_checks++;
        if (sb_if.busy_vec !== 32'h0) $display("FAIL flush_busy_clear: got %h want %h", sb_if.busy_vec, 32'h0);
        else n_pass++;
        n_checks++;
        if (sb_if.issue_tag !== 3'd3) $display("FAIL flush_tag_kept: got %0d want 3", sb_if.issue_tag);
        else n_pass++;
        n_stalls = 0;
        for (int i = 10; i <= 16; i++) begin
            drive_issue(1'b1, reg_idx_t'(i), 3'd0, 3'b000, 5'd0, 5'd0, 5'd0);
            #1;
            if (sb_if.stall !== 1'b0) n_stalls++;
            next_cycle();
        end
        n_checks++;
        if (n_stalls !== 0) $display("FAIL flush_inflight_cleared: got %0d stalls want 0", n_stalls);
        else n_pass++;
        drive_issue(1'b1, 5'd17, 3'd0, 3'b000, 5'd0, 5'd0, 5'd0);
        #1;
        n_checks++;
        if (sb_if.stall !== 1'b1) $display("FAIL flush_refill_full: got %b want 1", sb_if.stall);
        else n_pass++;
        next_cycle();
    endtask

    initial begin
        clear_inputs();
        sb_if.forwarding_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_no_forwarding();
        test_reissue();
        test_full();
        test_flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_register_scoreboard
`default_nettype wire
